// File: rtl/lms_pkg.sv
// lms_pkg: shared state encoding and default data width for laser_measure_sched
package lms_pkg;
    localparam int LMS_DW = 16;
    typedef logic [2:0] state_t;
    localparam state_t IDLE  = 3'd0;
    localparam state_t TRIG  = 3'd1;
    localparam state_t WON   = 3'd2;
    localparam state_t WOFF  = 3'd3;
    localparam state_t CAPT  = 3'd4;
    localparam state_t GAPW  = 3'd5;
    localparam state_t DONE  = 3'd6;
    localparam state_t ABORT = 3'd7;
endpackage

// File: rtl/lms_timer.sv
// lms_timer: loadable down-counter that parks at zero; clk/reset, load_i+value_i load, zero_o flags zero
module lms_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q, cnt_d;
    assign zero_o = cnt_q == '0;
    always_comb cnt_d = load_i ? value_i : zero_o ? cnt_q : cnt_q - W'(1);
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/laser_measure_sched.sv
// laser_measure_sched: bursts of fsmd measurements averaged into avg/valid, with timeout recovery via R
// ports: clk, reset (sync high), go in; B trigger, R fsmd reset out; L, D from fsmd; avg, valid, err, busy out
module laser_measure_sched
    import lms_pkg::*;
#(
    parameter int DW         = LMS_DW,
    parameter int NSAMP_LOG2 = 2,
    parameter int TIMEOUT    = 1000,
    parameter int GAP        = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          go,
    output logic          B,
    output logic          R,
    input  logic          L,
    input  logic [DW-1:0] D,
    output logic [DW-1:0] avg,
    output logic          valid,
    output logic          err,
    output logic          busy
);
    localparam int AW   = DW + NSAMP_LOG2;
    localparam int NW   = NSAMP_LOG2 + 1;
    localparam int TMAX = TIMEOUT > GAP ? TIMEOUT : GAP;
    localparam int TW   = TMAX > 1 ? $clog2(TMAX) : 1;
    state_t          state_q, state_d;
    logic [AW-1:0]   acc_q, acc_d, sum;
    logic [NW-1:0]   n_q, n_d;
    logic [DW-1:0]   avg_q, avg_d;
    logic            err_q, err_d, r_q;
    logic            tmr_load, tmr_zero, start, capt, last;
    logic [TW-1:0]   tmr_val;
    lms_timer #(.W(TW)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load_i  (tmr_load),
        .value_i (tmr_val),
        .zero_o  (tmr_zero)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            n_q     <= '0;
            avg_q   <= '0;
            err_q   <= 1'b0;
            r_q     <= 1'b1;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            n_q     <= n_d;
            avg_q   <= avg_d;
            err_q   <= err_d;
            r_q     <= state_d == ABORT;
        end
    end
    // timeout wins over L in WON/WOFF; the timer is reloaded only in TRIG and CAPT
    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            IDLE:  state_d = go ? TRIG : IDLE;
            TRIG:  begin
                state_d  = WON;
                tmr_load = 1'b1;
                tmr_val  = TW'(TIMEOUT - 1);
            end
            WON:   state_d = tmr_zero ? ABORT : L ? WOFF : WON;
            WOFF:  state_d = tmr_zero ? ABORT : !L ? CAPT : WOFF;
            CAPT:  begin
                state_d  = last ? DONE : GAPW;
                tmr_load = !last;
                tmr_val  = TW'(GAP - 1);
            end
            GAPW:  state_d = tmr_zero ? TRIG : GAPW;
            default: state_d = IDLE;
        endcase
    end
    // the average is computed while capturing the last sample so avg and valid rise together
    always_comb begin
        start = state_q == IDLE && go;
        capt  = state_q == CAPT;
        last  = n_q == NW'(2**NSAMP_LOG2 - 1);
        sum   = acc_q + AW'(D);
        acc_d = start ? '0 : capt ? sum : acc_q;
        n_d   = start ? '0 : capt ? n_q + NW'(1) : n_q;
        avg_d = capt && last ? DW'(sum >> NSAMP_LOG2) : avg_q;
        err_d = start ? 1'b0 : state_q == ABORT ? 1'b1 : err_q;
    end
    always_comb begin
        B     = state_q == TRIG;
        valid = state_q == DONE;
        busy  = state_q != IDLE;
        R     = r_q;
        avg   = avg_q;
        err   = err_q;
    end
endmodule
